vblank_update_arbiter: RTL and testbench

- Shares the object-attribute write port (position, colour, visibility registers consumed by the display compare logic) among several game-logic requesters.
- Commits writes only inside a vertical-blanking window, so the pixel comparator never sees a half-updated object (no tearing).
- Uses round-robin arbitration and enforces a per-frame write budget.
- Sits between the game logic (player mover, scroll animator, screen loader, destination-rect logic) and the attribute register file. It is driven by the vertical counter.

---
 rtl/vga_ctrl_pkg.sv | 23 ++
 rtl/vblank_update_arbiter_if.sv | 25 ++
 rtl/rr_picker.sv | 31 +++
 rtl/vblank_update_arbiter.sv | 156 +++++++++++++++
 tb/tb_vblank_update_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the VGA attribute-update path.
// Holds the arbiter state encoding, default frame geometry and a clog2 helper.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    StActive    = 2'd0,
    StBlank     = 2'd1,
    StExhausted = 2'd2
  } arb_state_t;

  localparam int unsigned DefHTotal  = 800;
  localparam int unsigned DefVTotal  = 521;
  localparam int unsigned DefVActive = 480;

  // Ceiling log2; callers pass values >= 2 so the result is never zero.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/vblank_update_arbiter_if.sv
// Request/commit bundle between game-logic requesters, the arbiter and the attribute file.
// master = requester side, slave = arbiter side.
interface vblank_update_arbiter_if #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned AddrW  = 8,
  parameter int unsigned DataW  = 32
);
  logic [NumReq-1:0]       req;
  logic [NumReq*AddrW-1:0] req_addr;
  logic [NumReq*DataW-1:0] req_data;
  logic [NumReq-1:0]       gnt;
  logic                    wr_en;
  logic [AddrW-1:0]        wr_addr;
  logic [DataW-1:0]        wr_data;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req at or after ptr (ascending, wrapping).
module rr_picker
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned PtrW  = clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PtrW-1:0]   idx_o,
  output logic              valid_o
);

  // k is the search distance from ptr; the first hit in distance order wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (!valid_o && req_i[i] && (i == (32'(ptr_i) + k) % NumReq)) begin
          valid_o  = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = PtrW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/vblank_update_arbiter.sv
// Round-robin attribute-write arbiter that commits only inside vertical blanking,
// with a per-frame write budget. Optional UPDATE_STATS_EN adds per-requester miss counters.
module vblank_update_arbiter
  import vga_ctrl_pkg::*;
#(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned AddrW      = 8,
  parameter int unsigned DataW      = 32,
  parameter int unsigned VActive    = DefVActive,
  parameter int unsigned VTotal     = DefVTotal,
  parameter int unsigned GuardLines = 2,
  parameter int unsigned MaxWr      = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [31:0]          vcount_i,
  vblank_update_arbiter_if.slave bus,
  output logic                 frame_tick_o,
  output logic                 budget_hit_o
`ifdef UPDATE_STATS_EN
  ,
  input  logic                 stats_clr_i,
  output logic [NumReq*8-1:0]  miss_cnt_o
`endif
);

  localparam int unsigned PtrW = clog2(NumReq);
  localparam int unsigned CntW = clog2(MaxWr + 1);

  arb_state_t        state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [AddrW-1:0]  wr_addr_q, wr_addr_d;
  logic [DataW-1:0]  wr_data_q, wr_data_d;
  logic              frame_tick_q, frame_tick_d;

  logic              win;
  logic              grant_en;
  logic              xfer;
  logic [NumReq-1:0] pick_gnt;
  logic [PtrW-1:0]   pick_idx;
  logic              pick_valid;

  assign win = (vcount_i >= 32'(VActive)) && (vcount_i < 32'(VTotal - GuardLines));

  rr_picker #(
    .NumReq (NumReq)
  ) u_picker (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Gating on win as well as state keeps the grant off on the cycle the window closes.
  assign grant_en = (state_q == StBlank) && win;
  assign bus.gnt  = grant_en ? pick_gnt : '0;
  assign xfer     = grant_en && pick_valid;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    wr_cnt_d     = wr_cnt_q;
    wr_en_d      = xfer;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_tick_d = 1'b0;

    unique case (state_q)
      StActive: begin
        if (win) begin
          state_d      = StBlank;
          frame_tick_d = 1'b1;
          wr_cnt_d     = '0;
        end
      end
      StBlank: begin
        if (!win) begin
          state_d = StActive;
        end else if (xfer && (wr_cnt_q == CntW'(MaxWr - 1))) begin
          state_d = StExhausted;
        end
      end
      StExhausted: begin
        if (!win) state_d = StActive;
      end
      default: state_d = StActive;
    endcase

    if (xfer) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (pick_gnt[i]) begin
          wr_addr_d = bus.req_addr[i*AddrW +: AddrW];
          wr_data_d = bus.req_data[i*DataW +: DataW];
        end
      end
      rr_ptr_d = (pick_idx == PtrW'(NumReq - 1)) ? '0 : pick_idx + PtrW'(1);
      wr_cnt_d = wr_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StActive;
      rr_ptr_q     <= '0;
      wr_cnt_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign frame_tick_o  = frame_tick_q;
  assign budget_hit_o  = (state_q == StExhausted);

`ifdef UPDATE_STATS_EN
  logic [NumReq-1:0][7:0] miss_q, miss_d;
  logic                   leave_win;

  // Any req still high as the window closes was never granted this frame.
  assign leave_win = (state_q != StActive) && !win;

  always_comb begin
    miss_d = miss_q;
    if (stats_clr_i) begin
      miss_d = '0;
    end else if (leave_win) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (bus.req[i] && (miss_q[i] != 8'hFF)) miss_d[i] = miss_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) miss_q <= '0;
    else         miss_q <= miss_d;
  end

  assign miss_cnt_o = miss_q;
`endif

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Bench for vblank_update_arbiter: directed table, reset and random stimulus against a
// frame-level reference model; runs a default-budget and a 3-write-budget instance in parallel.
module tb_vblank_update_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned VAct  = 480;
  localparam int unsigned VTot  = 521;
  localparam int unsigned Guard = 2;
  localparam int unsigned MaxA  = 64;
  localparam int unsigned MaxB  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   vc = '0;
  logic [N-1:0]  req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          tick_a, tick_b, bh_a, bh_b;
  logic [N*8-1:0] miss_a, miss_b;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  vblank_update_arbiter_if #(.NumReq(N), .AddrW(AW), .DataW(DW)) bus_a ();
  vblank_update_arbiter_if #(.NumReq(N), .AddrW(AW), .DataW(DW)) bus_b ();

  assign bus_a.req      = req;
  assign bus_a.req_addr = req_addr;
  assign bus_a.req_data = req_data;
  assign bus_b.req      = req;
  assign bus_b.req_addr = req_addr;
  assign bus_b.req_data = req_data;

`ifdef UPDATE_STATS_EN
  logic stats_clr = 1'b0;
`else
  assign miss_a = '0;
  assign miss_b = '0;
`endif

  vblank_update_arbiter #(
    .NumReq(N), .AddrW(AW), .DataW(DW), .VActive(VAct), .VTotal(VTot),
    .GuardLines(Guard), .MaxWr(MaxA)
  ) dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .vcount_i     (vc),
    .bus          (bus_a.slave),
    .frame_tick_o (tick_a),
    .budget_hit_o (bh_a)
`ifdef UPDATE_STATS_EN
    ,
    .stats_clr_i  (stats_clr),
    .miss_cnt_o   (miss_a)
`endif
  );

  vblank_update_arbiter #(
    .NumReq(N), .AddrW(AW), .DataW(DW), .VActive(VAct), .VTotal(VTot),
    .GuardLines(Guard), .MaxWr(MaxB)
  ) dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .vcount_i     (vc),
    .bus          (bus_b.slave),
    .frame_tick_o (tick_b),
    .budget_hit_o (bh_b)
`ifdef UPDATE_STATS_EN
    ,
    .stats_clr_i  (stats_clr),
    .miss_cnt_o   (miss_b)
`endif
  );

  // Reference model: a frame opens the cycle after win rises; within it grants follow a
  // round-robin pointer until the budget is spent.
  logic         m_prev_win;
  int           m_cnt [2];
  int           m_ptr [2];
  int           m_max [2];
  logic         m_wr_en [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  logic         m_tick;
  int           m_miss [2][N];
  logic [N-1:0] m_gnt [2];

  function automatic logic in_win(input logic [31:0] v);
    return (v >= VAct) && (v < VTot - Guard);
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] g;
    g = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (r[(p + k) % N]) begin
        g = '0;
        g[(p + k) % N] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev_win = 1'b0;
    m_tick     = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_cnt[m]   = 0;
      m_ptr[m]   = 0;
      m_wr_en[m] = 1'b0;
      m_addr[m]  = '0;
      m_data[m]  = '0;
      m_gnt[m]   = '0;
      for (int i = 0; i < N; i++) m_miss[m][i] = 0;
    end
  endtask

  task automatic check_inst(input int m, input logic [N-1:0] g, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d, input logic t,
                            input logic bh, input logic [N*8-1:0] ms);
    string s;
    s = (m == 0) ? "a" : "b";
    chk({"gnt_", s}, 64'(g), 64'(m_gnt[m]));
    chk({"wr_en_", s}, 64'(we), 64'(m_wr_en[m]));
    chk({"wr_addr_", s}, 64'(a), 64'(m_addr[m]));
    chk({"wr_data_", s}, 64'(d), 64'(m_data[m]));
    chk({"frame_tick_", s}, 64'(t), 64'(m_tick));
    chk({"budget_hit_", s}, 64'(bh), 64'(m_prev_win && (m_cnt[m] == m_max[m])));
`ifdef UPDATE_STATS_EN
    for (int i = 0; i < N; i++) chk({"miss_cnt_", s}, 64'(ms[i*8 +: 8]), 64'(m_miss[m][i]));
`else
    if (ms !== '0) chk({"miss_stub_", s}, 64'(ms), 64'd0);
`endif
  endtask

  // Called at the falling edge: compare, then advance the model across the next rising edge.
  task automatic model_cycle();
    logic w;
    w = in_win(vc);
    for (int m = 0; m < 2; m++)
      m_gnt[m] = (w && m_prev_win && (m_cnt[m] < m_max[m])) ? rr_pick(req, m_ptr[m]) : '0;
    check_inst(0, bus_a.gnt, bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data, tick_a, bh_a, miss_a);
    check_inst(1, bus_b.gnt, bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data, tick_b, bh_b, miss_b);
    for (int m = 0; m < 2; m++) begin
      m_wr_en[m] = |m_gnt[m];
      for (int i = 0; i < N; i++) begin
        if (m_gnt[m][i]) begin
          m_addr[m] = req_addr[i*AW +: AW];
          m_data[m] = req_data[i*DW +: DW];
          m_ptr[m]  = (i + 1) % N;
          m_cnt[m]++;
        end
      end
`ifdef UPDATE_STATS_EN
      for (int i = 0; i < N; i++) begin
        if (stats_clr) m_miss[m][i] = 0;
        else if (m_prev_win && !w && req[i] && m_miss[m][i] < 255) m_miss[m][i]++;
      end
`endif
      if (w && !m_prev_win) m_cnt[m] = 0;
    end
    m_tick     = w && !m_prev_win;
    m_prev_win = w;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef UPDATE_STATS_EN
  task automatic frame();
    vc = 480; step();
    vc = 519; step();
    vc = 0;   step();
  endtask
`endif

  typedef struct {
    logic [31:0]   vc;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic          tick;
    logic [N-1:0]  gnt_b;
    logic          bh_b;
  } vec_t;

  vec_t tbl [15];
  logic [N-1:0] pend;

  initial begin
    tbl[0]  = '{100, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{100, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{480, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0};
    tbl[3]  = '{480, 4'b0001, 4'b0001, 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0};
    tbl[4]  = '{480, 4'b1111, 4'b0010, 1'b1, 8'h10, 1'b0, 4'b0010, 1'b0};
    tbl[5]  = '{480, 4'b1111, 4'b0100, 1'b1, 8'h11, 1'b0, 4'b0100, 1'b0};
    tbl[6]  = '{480, 4'b1111, 4'b1000, 1'b1, 8'h12, 1'b0, 4'b0000, 1'b1};
    tbl[7]  = '{480, 4'b1111, 4'b0001, 1'b1, 8'h13, 1'b0, 4'b0000, 1'b1};
    tbl[8]  = '{518, 4'b1111, 4'b0010, 1'b1, 8'h10, 1'b0, 4'b0000, 1'b1};
    tbl[9]  = '{519, 4'b1111, 4'b0000, 1'b1, 8'h11, 1'b0, 4'b0000, 1'b1};
    tbl[10] = '{519, 4'b1111, 4'b0000, 1'b0, 8'h11, 1'b0, 4'b0000, 1'b0};
    tbl[11] = '{0,   4'b1000, 4'b0000, 1'b0, 8'h11, 1'b0, 4'b0000, 1'b0};
    tbl[12] = '{480, 4'b1000, 4'b0000, 1'b0, 8'h11, 1'b0, 4'b0000, 1'b0};
    tbl[13] = '{480, 4'b1000, 4'b1000, 1'b0, 8'h11, 1'b1, 4'b1000, 1'b0};
    tbl[14] = '{480, 4'b0000, 4'b0000, 1'b1, 8'h13, 1'b0, 4'b0000, 1'b0};

    m_max[0] = MaxA;
    m_max[1] = MaxB;
    model_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(8'h10 + i);
      req_data[i*DW +: DW] = 32'hD000_0000 | i;
    end

    #12;
    chk("reset_wr_en", 64'(bus_a.wr_en), 64'd0);
    chk("reset_gnt", 64'(bus_a.gnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed table: window entry, rotation, budget exhaustion, guard band, carry-over.
    for (int r = 0; r < 15; r++) begin
      vc  = tbl[r].vc;
      req = tbl[r].req;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt_a", r), 64'(bus_a.gnt), 64'(tbl[r].gnt_a));
      chk($sformatf("tbl%0d_wr_en_a", r), 64'(bus_a.wr_en), 64'(tbl[r].we_a));
      chk($sformatf("tbl%0d_wr_addr_a", r), 64'(bus_a.wr_addr), 64'(tbl[r].addr_a));
      chk($sformatf("tbl%0d_tick", r), 64'(tick_a), 64'(tbl[r].tick));
      chk($sformatf("tbl%0d_gnt_b", r), 64'(bus_b.gnt), 64'(tbl[r].gnt_b));
      chk($sformatf("tbl%0d_bh_b", r), 64'(bh_b), 64'(tbl[r].bh_b));
      model_cycle();
      @(posedge clk); #1;
    end

    // Reset while a commit strobe is high.
    vc = 480; req = 4'b0001;
    step();
    chk("pre_reset_wr_en", 64'(bus_a.wr_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en_a", 64'(bus_a.wr_en), 64'd0);
    chk("rst_wr_addr_a", 64'(bus_a.wr_addr), 64'd0);
    chk("rst_wr_data_a", 64'(bus_a.wr_data), 64'd0);
    chk("rst_gnt_a", 64'(bus_a.gnt), 64'd0);
    chk("rst_tick_b", 64'(tick_b), 64'd0);
    chk("rst_bh_b", 64'(bh_b), 64'd0);
    chk("rst_wr_en_b", 64'(bus_b.wr_en), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_gnt", 64'(bus_a.gnt), 64'd0);
    model_cycle();
    @(posedge clk); #1;

    // Random traffic with requesters holding until granted by instance a.
    vc = 470; req = '0; pend = '0;
    for (int c = 0; c < 4000; c++) begin
      int unsigned r;
      r = $urandom_range(0, 199);
      if (r == 0) vc = $urandom_range(0, 530);
      else if (r < 60) begin
        vc = vc + 1;
        if (vc >= VTot) vc = 460;
      end
      for (int i = 0; i < N; i++) begin
        if (m_gnt[0][i]) pend[i] = 1'b0;
        else if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom);
          req_data[i*DW +: DW] = $urandom;
        end
      end
      req = pend;
      step();
    end

`ifdef UPDATE_STATS_EN
    req = '0; vc = 0;
    step(); step();
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    req = 4'b0100;
    repeat (2) frame();
    chk("miss2_a", 64'(miss_a[16 +: 8]), 64'd2);
    chk("miss2_b", 64'(miss_b[16 +: 8]), 64'd2);
    chk("miss0_a", 64'(miss_a[0 +: 8]), 64'd0);
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    chk("miss_clr_a", 64'(miss_a[16 +: 8]), 64'd0);
    repeat (300) frame();
    chk("miss_sat_a", 64'(miss_a[16 +: 8]), 64'd255);
    chk("miss_sat_b", 64'(miss_b[16 +: 8]), 64'd255);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
